// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (CPU, host) arbiter for a single-port data memory.
// Each access owns the memory for one cycle; read data is registered and
// returned to the owner on the following cycle. Ties go to the requester that
// was not served by the most recent grant.
// Optional feature: define MEM_ARB_HOST_LOCK_EN to let the host hold exclusive
// ownership via host_lock; without it host_lock is ignored and no lock state
// exists.
module mem_arbiter #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  // CPU requester
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  // host / loader requester
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  input  logic          host_lock,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  // data memory
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_ACC  = 2'd1,
    HOST_ACC = 2'd2
  } state_e;

  typedef enum logic {
    OWN_CPU  = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

  state_e          state_q, state_d;
  owner_e          last_q, last_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            we_q, we_d;
  logic            cpu_rvalid_q, cpu_rvalid_d;
  logic            host_rvalid_q, host_rvalid_d;
  logic [DW-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0]   host_rdata_q, host_rdata_d;

  logic            cpu_own_c;
  logic            host_own_c;
  logic            lock_block_c;
  logic            cpu_elig_c;
  logic            host_elig_c;
  logic            cpu_win_c;
  logic            host_win_c;

  // Ownership of the current cycle is decoded straight from the state register
  assign cpu_own_c  = (state_q == CPU_ACC);
  assign host_own_c = (state_q == HOST_ACC);

`ifdef MEM_ARB_HOST_LOCK_EN
  logic lock_q, lock_d;

  // The lock keeps the CPU out only while host_lock stays high; the edge that
  // sees host_lock=0 both clears the lock and lets the CPU compete.
  assign lock_block_c = lock_q & host_lock;

  // Lock is armed by a host acceptance with host_lock=1, cleared by host_lock=0
  always_comb begin
    lock_d = lock_q;
    if (host_win_c && host_lock) begin
      lock_d = 1'b1;
    end else if (!host_lock) begin
      lock_d = 1'b0;
    end
  end

  // Lock register
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q <= 1'b0;
    end else begin
      lock_q <= lock_d;
    end
  end
`else
  logic unused_host_lock;

  assign unused_host_lock = host_lock;
  assign lock_block_c     = 1'b0;
`endif

  // A requester may win only if it is not being served in the current cycle
  assign cpu_elig_c  = cpu_req & ~cpu_own_c & ~lock_block_c;
  assign host_elig_c = host_req & ~host_own_c;

  // Tie-break: the side not served by the last grant wins
  assign cpu_win_c  = cpu_elig_c & (~host_elig_c | (last_q == OWN_HOST));
  assign host_win_c = host_elig_c & ~cpu_win_c;

  // Next state, payload capture, pointer update and read-data return
  always_comb begin
    state_d       = IDLE;
    last_d        = last_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    we_d          = we_q;
    cpu_rvalid_d  = 1'b0;
    host_rvalid_d = 1'b0;
    cpu_rdata_d   = cpu_rdata_q;
    host_rdata_d  = host_rdata_q;

    // Capture read data at the end of the access cycle for its owner
    if (cpu_own_c && !we_q) begin
      cpu_rvalid_d = 1'b1;
      cpu_rdata_d  = mem_rdata;
    end
    if (host_own_c && !we_q) begin
      host_rvalid_d = 1'b1;
      host_rdata_d  = mem_rdata;
    end

    if (cpu_win_c) begin
      state_d = CPU_ACC;
      last_d  = OWN_CPU;
      addr_d  = cpu_addr;
      wdata_d = cpu_wdata;
      we_d    = cpu_we;
    end else if (host_win_c) begin
      state_d = HOST_ACC;
      last_d  = OWN_HOST;
      addr_d  = host_addr;
      wdata_d = host_wdata;
      we_d    = host_we;
    end
  end

  // State, pointer, payload and read-return registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_q        <= OWN_HOST;
      addr_q        <= '0;
      wdata_q       <= '0;
      we_q          <= 1'b0;
      cpu_rvalid_q  <= 1'b0;
      host_rvalid_q <= 1'b0;
      cpu_rdata_q   <= '0;
      host_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      we_q          <= we_d;
      cpu_rvalid_q  <= cpu_rvalid_d;
      host_rvalid_q <= host_rvalid_d;
      cpu_rdata_q   <= cpu_rdata_d;
      host_rdata_q  <= host_rdata_d;
    end
  end

  // Output decode from registered state and payload
  always_comb begin
    cpu_gnt     = 1'b0;
    host_gnt    = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = addr_q;
    mem_wdata   = wdata_q;
    cpu_rvalid  = cpu_rvalid_q;
    host_rvalid = host_rvalid_q;
    cpu_rdata   = cpu_rdata_q;
    host_rdata  = host_rdata_q;
    if (state_q != IDLE) begin
      cpu_gnt   = cpu_own_c;
      host_gnt  = host_own_c;
      mem_write = we_q;
      mem_read  = ~we_q;
    end
  end

  // CPU is stalled whenever it asks and is not being served this cycle
  assign cpu_stall = cpu_req & ~cpu_own_c;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural data memory.
module tb_mem_arbiter;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;

  logic          clk;
  logic          rst;
  logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid, cpu_stall;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          host_req, host_we, host_lock, host_gnt, host_rvalid;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata, host_rdata;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [DW-1:0] mem [0:255];
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;

  int total;
  int bad;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_gnt     (cpu_gnt),
    .cpu_rvalid  (cpu_rvalid),
    .cpu_rdata   (cpu_rdata),
    .cpu_stall   (cpu_stall),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_lock   (host_lock),
    .host_gnt    (host_gnt),
    .host_rvalid (host_rvalid),
    .host_rdata  (host_rdata),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: combinational read, write on the strobe, side port for preload
  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_address] <= mem_wdata;
    end else if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end
  end
  assign mem_rdata = mem[mem_address];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    step();
    ld_en   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    bit seen;
    int hgnts;
    total      = 0;
    bad        = 0;
    rst        = 1'b1;
    cpu_req    = 1'b0;
    cpu_we     = 1'b0;
    cpu_addr   = '0;
    cpu_wdata  = '0;
    host_req   = 1'b0;
    host_we    = 1'b0;
    host_addr  = '0;
    host_wdata = '0;
    host_lock  = 1'b0;
    ld_en      = 1'b0;
    ld_addr    = '0;
    ld_data    = '0;

    preload(8'h10, 32'hDEADBEEF);
    preload(8'h20, 32'h11112222);
    preload(8'h21, 32'h33334444);
    do_reset();

    // Reset state
    check("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
    check("rst_host_gnt", 32'(host_gnt), 32'd0);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    check("rst_host_rvalid", 32'(host_rvalid), 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    check("rst_host_rdata", host_rdata, 32'd0);
    check("rst_mem_address", 32'(mem_address), 32'd0);

    // Single CPU read of 0x10
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 8'h10;
    #1;
    check("rd_stall_c0", 32'(cpu_stall), 32'd1);
    step();
    check("rd_gnt_c1", 32'(cpu_gnt), 32'd1);
    check("rd_mem_read_c1", 32'(mem_read), 32'd1);
    check("rd_mem_write_c1", 32'(mem_write), 32'd0);
    check("rd_addr_c1", 32'(mem_address), 32'h10);
    check("rd_stall_c1", 32'(cpu_stall), 32'd0);
    cpu_req = 1'b0;
    step();
    check("rd_rvalid_c2", 32'(cpu_rvalid), 32'd1);
    check("rd_rdata_c2", cpu_rdata, 32'hDEADBEEF);
    check("rd_gnt_c2", 32'(cpu_gnt), 32'd0);
    check("rd_host_rvalid_c2", 32'(host_rvalid), 32'd0);
    step();
    check("rd_rvalid_c3", 32'(cpu_rvalid), 32'd0);
    check("rd_rdata_hold_c3", cpu_rdata, 32'hDEADBEEF);

    // Simultaneous requests: C,H,C,H then pointer favours CPU on next tie
    do_reset();
    cpu_req   = 1'b1;
    cpu_addr  = 8'h20;
    host_req  = 1'b1;
    host_we   = 1'b0;
    host_addr = 8'h21;
    step();
    check("alt1_cpu_gnt", 32'(cpu_gnt), 32'd1);
    check("alt1_host_gnt", 32'(host_gnt), 32'd0);
    step();
    check("alt2_cpu_gnt", 32'(cpu_gnt), 32'd0);
    check("alt2_host_gnt", 32'(host_gnt), 32'd1);
    check("alt2_mem_addr", 32'(mem_address), 32'h21);
    check("alt2_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    check("alt2_cpu_rdata", cpu_rdata, 32'h11112222);
    step();
    check("alt3_cpu_gnt", 32'(cpu_gnt), 32'd1);
    check("alt3_host_rvalid", 32'(host_rvalid), 32'd1);
    check("alt3_host_rdata", host_rdata, 32'h33334444);
    step();
    check("alt4_host_gnt", 32'(host_gnt), 32'd1);
    cpu_req  = 1'b0;
    host_req = 1'b0;
    step();
    check("alt_idle_cpu_gnt", 32'(cpu_gnt), 32'd0);
    check("alt_idle_host_gnt", 32'(host_gnt), 32'd0);
    cpu_req  = 1'b1;
    host_req = 1'b1;
    step();
    check("ptr_tie_cpu_gnt", 32'(cpu_gnt), 32'd1);
    check("ptr_tie_host_gnt", 32'(host_gnt), 32'd0);
    cpu_req  = 1'b0;
    host_req = 1'b0;
    step();
    step();

    // Host write of 0x55 to 0x3, then CPU read-back
    host_req   = 1'b1;
    host_we    = 1'b1;
    host_addr  = 8'h03;
    host_wdata = 32'h55;
    step();
    check("hw_host_gnt", 32'(host_gnt), 32'd1);
    check("hw_mem_write", 32'(mem_write), 32'd1);
    check("hw_mem_read", 32'(mem_read), 32'd0);
    check("hw_addr", 32'(mem_address), 32'h3);
    check("hw_wdata", mem_wdata, 32'h55);
    host_req = 1'b0;
    step();
    check("hw_mem_write_off", 32'(mem_write), 32'd0);
    check("hw_no_rvalid", 32'(host_rvalid), 32'd0);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 8'h03;
    step();
    check("rb_cpu_gnt", 32'(cpu_gnt), 32'd1);
    cpu_req = 1'b0;
    step();
    check("rb_rvalid", 32'(cpu_rvalid), 32'd1);
    check("rb_rdata", cpu_rdata, 32'h55);

    // Lone requester held high: granted every other cycle
    cpu_req  = 1'b1;
    cpu_addr = 8'h10;
    step();
    check("lone1_gnt", 32'(cpu_gnt), 32'd1);
    step();
    check("lone2_gnt", 32'(cpu_gnt), 32'd0);
    check("lone2_stall", 32'(cpu_stall), 32'd1);
    step();
    check("lone3_gnt", 32'(cpu_gnt), 32'd1);

    // Reset during a CPU read grant aborts the access
    rst     = 1'b1;
    cpu_req = 1'b0;
    step();
    rst = 1'b0;
    check("abort_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    check("abort_cpu_gnt", 32'(cpu_gnt), 32'd0);
    check("abort_mem_read", 32'(mem_read), 32'd0);
    check("abort_mem_write", 32'(mem_write), 32'd0);
    check("abort_cpu_rdata", cpu_rdata, 32'd0);
    step();
    check("abort_cpu_rvalid_n2", 32'(cpu_rvalid), 32'd0);

`ifdef MEM_ARB_HOST_LOCK_EN
    // Locked host issues 3 writes while CPU waits
    do_reset();
    host_req   = 1'b1;
    host_we    = 1'b1;
    host_addr  = 8'h40;
    host_wdata = 32'h1;
    host_lock  = 1'b1;
    step();
    check("lock_first_host_gnt", 32'(host_gnt), 32'd1);
    hgnts    = 1;
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 8'h10;
    for (int i = 0; i < 4; i++) begin
      step();
      check("lock_cpu_stall", 32'(cpu_stall), 32'd1);
      check("lock_cpu_gnt", 32'(cpu_gnt), 32'd0);
      if (host_gnt) hgnts++;
    end
    check("lock_host_writes", 32'(hgnts), 32'd3);
    host_lock = 1'b0;
    host_req  = 1'b0;
    seen      = 1'b0;
    for (int i = 0; i < 2 && !seen; i++) begin
      step();
      if (cpu_gnt) seen = 1'b1;
    end
    check("lock_release_cpu_gnt", 32'(seen), 32'd1);
    cpu_req = 1'b0;
    step();
`else
    // Without the lock feature host_lock has no effect on the CPU
    do_reset();
    host_req  = 1'b1;
    host_we   = 1'b1;
    host_addr = 8'h40;
    host_lock = 1'b1;
    step();
    check("nolock_host_gnt", 32'(host_gnt), 32'd1);
    cpu_req  = 1'b1;
    cpu_addr = 8'h10;
    step();
    check("nolock_cpu_gnt", 32'(cpu_gnt), 32'd1);
    cpu_req   = 1'b0;
    host_req  = 1'b0;
    host_lock = 1'b0;
    step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 32, SHALL set the memory word-address width in bits.
REQ-002 Parameter DW, default 32, SHALL set the data width in bits.
REQ-003 The block SHALL use one clock, clk; reset is rst, synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 cpu_req / cpu_we  input  1 / 1  CPU access request / write (1) or read (0).
REQ-007 cpu_addr / cpu_wdata  input  AW / DW  CPU word address / write data, held while cpu_req=1 and not accepted.
REQ-008 cpu_gnt / cpu_rvalid  output  1 / 1  CPU access in progress this cycle / CPU read data valid.
REQ-009 cpu_rdata  output  DW  CPU read data.
REQ-010 cpu_stall  output  1  high while cpu_req=1 and the CPU request is not yet accepted.
REQ-011 host_req, host_we, host_addr, host_wdata, host_gnt, host_rvalid, host_rdata SHALL mirror the CPU ports for the host/loader requester.
REQ-012 host_lock  input  1  host request for exclusive ownership (see Configuration).
REQ-013 mem_read / mem_write  output  1 / 1  data memory read / write strobe.
REQ-014 mem_address / mem_wdata  output  AW / DW  data memory word address / write data.
REQ-015 mem_rdata  input  DW  data memory combinational read data.

Function
REQ-016 States SHALL be IDLE, CPU_ACC, HOST_ACC; the state register holds the owner of the current cycle.
REQ-017 A requester SHALL be eligible at an edge iff its req=1 and its gnt=0 in the cycle ending at that edge.
REQ-018 At each edge, the winner SHALL be the eligible requester; if both are eligible, the one not served by the most recent grant (last-winner pointer) wins.
REQ-019 On acceptance, the winner's addr, we and wdata SHALL be latched, the next state is CPU_ACC or HOST_ACC, and the winner's gnt is 1 for exactly the following cycle.
REQ-020 With no eligible requester, the next state SHALL be IDLE; gnt, mem_read and mem_write are 0 in IDLE.
REQ-021 In CPU_ACC/HOST_ACC, mem_address/mem_wdata SHALL come from the latched payload; mem_write=we and mem_read=~we.
REQ-022 For reads, mem_rdata SHALL be registered at the end of the access cycle; the owner's rvalid is 1 for exactly the next cycle with rdata equal to that value.
REQ-023 rdata SHALL hold its last value when rvalid=0; writes never assert rvalid.
REQ-024 Back-to-back accesses SHALL be allowed: with both requesters continuously eligible, grants alternate every cycle; a lone requester is granted at most every other cycle.
REQ-025 cpu_stall SHALL be combinational: cpu_req & ~cpu_gnt & ~(cpu accepted at the coming edge is unknown), i.e. cpu_req=1 and cpu_gnt=0.
REQ-026 mem_address and mem_wdata SHALL be passed unchanged as word addresses; no byte-to-word shift is applied.
REQ-027 The last-winner pointer SHALL update only on acceptance.

Reset
REQ-028 When rst=1 at an edge, the state SHALL become IDLE; all gnt, rvalid, mem_read and mem_write outputs are 0; rdata and latched payload are 0.
REQ-029 The last-winner pointer SHALL reset to HOST so the CPU wins the first tie.
REQ-030 Reset during an access SHALL abort it: no strobe in the following cycle, and any pending rvalid is dropped.

Configuration
REQ-031 With MEM_ARB_HOST_LOCK_EN defined, host_lock=1 sampled at a host acceptance SHALL make the CPU ineligible until an edge where host_lock=0; the lock clears on that edge.
REQ-032 With MEM_ARB_HOST_LOCK_EN defined, a locked host SHALL still follow REQ-017, and IDLE cycles during the lock are allowed.
REQ-033 Without MEM_ARB_HOST_LOCK_EN, host_lock SHALL be ignored and no lock state is built.

Verification
REQ-034 Reset, then cpu_req=1, we=0, addr=0x10 with mem[0x10]=0xDEADBEEF -> cpu_gnt=1 at cycle 1 with mem_read=1 and mem_address=0x10; cpu_rvalid=1 with cpu_rdata=0xDEADBEEF at cycle 2.
REQ-035 Both requests rise together after reset -> CPU granted first, host next cycle; with both held, gnt alternates C,H,C,H and the pointer is correct.
REQ-036 host write addr=0x3, wdata=0x55 -> mem_write=1 for one cycle and no host_rvalid; a subsequent CPU read of 0x3 returns 0x55.
REQ-037 With MEM_ARB_HOST_LOCK_EN defined and host_lock=1, host issues 3 writes while cpu_req=1 -> cpu_stall stays 1 and cpu_gnt=0 until host_lock=0; CPU is then granted within 2 cycles.
REQ-038 rst asserted in a CPU read gnt cycle -> no cpu_rvalid on the next cycle, state IDLE, all strobes 0.
